adc_stream_arbiter: RTL and testbench

//  Shares the single 128-bit PL->PS capture path between NUM_CH ADC channel streams.

---
 rtl/rfsoc_config_pkg.sv | 26 ++
 rtl/adc_stream_arbiter_pick.sv | 27 ++
 rtl/adc_stream_arbiter.sv | 118 +++++++++++
 tb/tb_adc_stream_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rfsoc_config_pkg.sv
// rfsoc_config: shared types and constants for the PL capture path.
// Header beat layout, arbiter state encoding and the flush bit of the PS control word.
package rfsoc_config;

    typedef enum logic [1:0] {IDLE, HDR, BURST} arb_state_t;

    localparam logic [15:0] ARB_SYNC_WORD    = 16'hA5C3;
    localparam int          HDR_SYNC_LSB     = 0;
    localparam int          HDR_CH_LSB       = 16;
    localparam int          HDR_SEQ_LSB      = 24;
    localparam int          HDR_LEN_LSB      = 40;
    localparam int          HDR_W            = 56;
    localparam int          ADC_BUFFER_FLUSH = 0;

    function automatic logic [HDR_W-1:0] arb_header(input logic [7:0] ch, input logic [15:0] seq,
                                                    input logic [15:0] len);
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_SYNC_LSB +: 16] = ARB_SYNC_WORD;
        h[HDR_CH_LSB +: 8]    = ch;
        h[HDR_SEQ_LSB +: 16]  = seq;
        h[HDR_LEN_LSB +: 16]  = len;
        return h;
    endfunction

endpackage

// File: rtl/adc_stream_arbiter_pick.sv
// rr_priority_pick: first set request at or after ptr, wrapping modulo N.
module rr_priority_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_pick,
    output logic         o_any
);

    logic [N-1:0] w_rot;
    logic [W-1:0] w_off;

    // Rotate so bit j is request (ptr+j) mod N; the lowest set bit is the winner.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (w_rot[i]) w_off = W'(i);
    end

    assign o_pick = W'((32'(i_ptr) + 32'(w_off)) % N);
    assign o_any  = |i_req;

endmodule

// File: rtl/adc_stream_arbiter.sv
// adc_stream_arbiter: round-robin burst arbiter merging NUM_CH ADC streams onto one registered AXIS output.
// Define ARB_HEADER_EN to emit a sync/grant/sequence/length header beat ahead of every burst.
module adc_stream_arbiter
    import rfsoc_config::*;
#(
    parameter int NUM_CH    = 4,
    parameter int BURST_LEN = 16,
    parameter int DATA_W    = 128,
    localparam int GW = $clog2(NUM_CH),
    localparam int CW = $clog2(BURST_LEN) + 1
) (
    input  logic                     pl_clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [15:0]              gpio_ctrl,
    output logic [GW-1:0]            grant_ch,
    output logic                     busy
);

    arb_state_t        r_state, w_state_nxt;
    logic [GW-1:0]     r_grant, r_rr_ptr, w_pick, w_rr_nxt;
    logic [CW-1:0]     r_beat_cnt;
    logic [15:0]       r_burst_seq;
    logic [DATA_W-1:0] r_m_tdata;
    logic              r_m_tvalid, r_busy;
    logic              w_any, w_flush, w_out_free, w_in_xfer, w_last, w_burst_end, w_unused;

`ifdef ARB_HEADER_EN
    localparam arb_state_t GRANT_ST = HDR;
    logic [DATA_W-1:0] w_hdr;
    assign w_hdr = DATA_W'(arb_header(8'(r_grant), r_burst_seq, 16'(BURST_LEN)));
`else
    localparam arb_state_t GRANT_ST = BURST;
`endif

    rr_priority_pick #(.N(NUM_CH)) u_pick (
        .i_req  (s_axis_tvalid & ch_enable),
        .i_ptr  (r_rr_ptr),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    assign w_flush     = gpio_ctrl[ADC_BUFFER_FLUSH];
    assign w_unused    = &{1'b0, gpio_ctrl};
    assign w_out_free  = !r_m_tvalid || m_axis_tready;
    assign s_axis_tready = (r_state == BURST && w_out_free) ? NUM_CH'(1) << r_grant : '0;
    assign w_in_xfer   = s_axis_tvalid[r_grant] && s_axis_tready[r_grant];
    assign w_last      = r_beat_cnt == CW'(BURST_LEN - 1);
    // A disabled channel ends its burst early; a plain tvalid gap only stalls it.
    assign w_burst_end = r_state == BURST && ((w_in_xfer && w_last) || !ch_enable[r_grant]);
    assign w_rr_nxt    = (r_grant == GW'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;

    always_comb begin
        w_state_nxt = w_flush                        ? IDLE :
                      (r_state == IDLE && w_any)     ? GRANT_ST :
                      (r_state == HDR && w_out_free) ? BURST :
                      w_burst_end                    ? IDLE : r_state;
    end

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_burst_seq <= '0;
            r_m_tdata   <= '0;
            r_m_tvalid  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_flush) begin
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_burst_seq <= '0;
            r_m_tdata   <= '0;
            r_m_tvalid  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (r_m_tvalid && m_axis_tready) r_m_tvalid <= 1'b0;
            if (r_state == IDLE && w_any) begin
                r_grant    <= w_pick;
                r_beat_cnt <= '0;
                r_busy     <= 1'b1;
            end
`ifdef ARB_HEADER_EN
            if (r_state == HDR && w_out_free) begin
                r_m_tdata  <= w_hdr;
                r_m_tvalid <= 1'b1;
            end
`endif
            if (w_in_xfer) begin
                r_m_tdata  <= s_axis_tdata[r_grant*DATA_W +: DATA_W];
                r_m_tvalid <= 1'b1;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_burst_end) begin
                r_rr_ptr    <= w_rr_nxt;
                r_burst_seq <= r_burst_seq + 1'b1;
                r_busy      <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign grant_ch      = r_grant;
    assign busy          = r_busy;

endmodule

// File: tb/tb_adc_stream_arbiter.sv
// tb_adc_stream_arbiter: directed scenarios for adc_stream_arbiter with a queue scoreboard of expected output beats.
// Sources are finite counters per channel; words encode channel and index so order errors are visible.
module tb_adc_stream_arbiter;

    localparam int NC = 4;
    localparam int DW = 128;
    localparam int BL = 16;
`ifdef ARB_HEADER_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NC*DW-1:0] s_tdata;
    logic [NC-1:0]  s_tvalid, s_tready, ch_enable, adv, forbid;
    logic [DW-1:0]  m_tdata, p_d, e, last_hdr;
    logic           m_tvalid, m_tready, busy, p_v, p_r, p_f, rnd_rdy;
    logic [15:0]    gpio, exp_seq;
    logic [1:0]     grant;
    logic [31:0]    cnt [NC];
    logic [31:0]    lim [NC];
    logic [DW-1:0]  q [$];
    int             out_cyc [$];
    int             cyc = 0;
    int             checks = 0;
    int             errors = 0;
    logic [31:0]    base;

    always #5 clk = ~clk;

    adc_stream_arbiter dut (
        .pl_clk        (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .ch_enable     (ch_enable),
        .gpio_ctrl     (gpio),
        .grant_ch      (grant),
        .busy          (busy)
    );

    function automatic logic [DW-1:0] word(input int c, input logic [31:0] n);
        return {64'hDA7A_0000_0000_0000 | 64'(c), n, 32'h0};
    endfunction

    function automatic logic [DW-1:0] hdr(input int c, input logic [15:0] s);
        return {72'h0, 16'(BL), s, 8'(c), 16'hA5C3};
    endfunction

    for (genvar g = 0; g < NC; g++) begin : g_src
        assign s_tdata[g*DW +: DW] = word(g, cnt[g]);
        assign s_tvalid[g]         = cnt[g] < lim[g];
        always @(posedge clk)
            if (!rst)        cnt[g] <= '0;
            else if (adv[g]) cnt[g] <= cnt[g] + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled mid-cycle, a valid&ready here is the transfer at the next rising edge.
    always @(negedge clk) begin
        adv <= s_tvalid & s_tready;
        if (rst) begin
            if (p_v && !p_r && !p_f) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", m_tdata, p_d);
            end
            check("ready_onehot", $onehot0(s_tready), 1);
            check("ready_forbid", s_tready & forbid, 0);
            if (m_tvalid && m_tready) begin
                out_cyc.push_back(cyc);
                if (m_tdata[15:0] == 16'hA5C3) last_hdr <= m_tdata;
                check("beat_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("beat_data", m_tdata, e);
                end
            end
        end
        p_v <= m_tvalid;
        p_r <= m_tready;
        p_f <= gpio[0];
        p_d <= m_tdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
        m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic feed(input int c, input int n);
`ifdef ARB_HEADER_EN
        q.push_back(hdr(c, exp_seq));
`endif
        exp_seq++;
        for (int i = 0; i < n; i++) q.push_back(word(c, lim[c] + 32'(i)));
        lim[c] = lim[c] + 32'(n);
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (q.size() == 0 && !busy && !m_tvalid) break;
        end
        check("drain_done", i < budget, 1);
    endtask

    task automatic wait_cnt(input int c, input logic [31:0] target, input int budget);
        for (int i = 0; i < budget && cnt[c] != target; i++) step();
        check("beat_reached", cnt[c], target);
    endtask

    task automatic flush();
        step();
        gpio[0] = 1'b1;
        step();
        gpio[0] = 1'b0;
        exp_seq = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        gpio = '0; ch_enable = '1; m_tready = 1'b1; rnd_rdy = 1'b0; forbid = '0; exp_seq = '0;
        for (int c = 0; c < NC; c++) lim[c] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        rst = 1'b1;

        // Single requester: two back-to-back bursts with one idle cycle between them.
        feed(0, BL);
        feed(0, BL);
        drain(200);
        check("t1_beats", out_cyc.size(), 2 * (BL + H));
        check("t1_burst_span", out_cyc[BL-1+H] - out_cyc[0], BL - 1 + H);
        check("t1_gap", out_cyc[BL+H] - out_cyc[BL-1+H], 2);
        check("t1_burst2_span", out_cyc[2*(BL+H)-1] - out_cyc[BL+H], BL - 1 + H);

        // Flush resets rr_ptr, so a full contention round starts at ch0.
        flush();
        feed(0, BL); feed(1, BL); feed(2, BL); feed(3, BL); feed(0, BL);
        drain(400);
        check("t2_grant", grant, 0);

        // Random output back-pressure across four bursts.
        rnd_rdy = 1'b1;
        feed(1, BL); feed(2, BL); feed(3, BL); feed(0, BL);
        drain(2000);
        rnd_rdy = 1'b0;
        check("t3_grant", grant, 0);

        // Only ch1/ch3 enabled while all four sources have data.
        ch_enable = 4'b1010;
        forbid = 4'b0101;
        lim[0] = lim[0] + 32;
        lim[2] = lim[2] + 32;
        feed(1, BL); feed(3, BL); feed(1, BL); feed(3, BL);
        drain(400);
        check("t4_grant", grant, 3);
        forbid = '0;
        lim[0] = cnt[0];
        lim[2] = cnt[2];
        ch_enable = '1;

        // Flush while beat 6 of a ch2 burst is stalled in the output register.
        base = lim[2];
        feed(2, 6);
        lim[2] = base + BL;
        wait_cnt(2, base + 7, 100);
        gpio[0] = 1'b1;
        m_tready = 1'b0;
        lim[2] = cnt[2];
        check("t5_delivered", q.size(), 0);
        step();
        check("t5_tvalid", m_tvalid, 0);
        check("t5_tdata", m_tdata, 0);
        check("t5_busy", busy, 0);
        check("t5_tready", s_tready, 0);
        gpio[0] = 1'b0;
        exp_seq = '0;
        feed(0, BL);
        feed(1, BL);
        step();
        check("t5_next_grant", grant, 0);
        check("t5_next_busy", busy, 1);
        drain(400);

        // ch_enable drop ends a ch3 burst after six beats; rr_ptr still advances past ch3.
        base = lim[3];
        feed(3, 6);
        lim[3] = base + BL;
        wait_cnt(3, base + 5, 100);
        ch_enable = 4'b0111;
        lim[3] = base + 6;
        drain(100);
        check("t7_partial_grant", grant, 3);
        ch_enable = '1;
        feed(0, BL);
        feed(3, BL);
        drain(400);

        // ch1 burst carrying sequence number 5.
        feed(1, BL);
        drain(200);
        check("t6_grant", grant, 1);
`ifdef ARB_HEADER_EN
        check("t6_hdr_sync", last_hdr[15:0], 16'hA5C3);
        check("t6_hdr_ch", last_hdr[23:16], 8'd1);
        check("t6_hdr_seq", last_hdr[39:24], 16'd5);
        check("t6_hdr_len", last_hdr[55:40], 16'(BL));
`endif
        check("final_queue", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
